// File: rtl/cpu_pkg.sv
// Shared encodings, state/ALU/immediate enums and the immediate generator for the multi-cycle core.
package cpu_pkg;

  // Major opcodes
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  // ALU funct3
  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Slt  = 3'b010;
  localparam logic [2:0] F3Sltu = 3'b011;
  localparam logic [2:0] F3Xor  = 3'b100;
  localparam logic [2:0] F3Sr   = 3'b101;
  localparam logic [2:0] F3Or   = 3'b110;
  localparam logic [2:0] F3And  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  // Only word accesses exist
  localparam logic [2:0] F3Word = 3'b010;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] ir, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      ImmS:    imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      ImmB:    imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      ImmU:    imm = {ir[31:12], 12'b0};
      ImmJ:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port, x0 = 0.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] regs_q [NREG];

  // Register array: cleared on reset, x0 never written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core with a single shared req/ack memory port and a terminal halt state.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int unsigned      DW       = 32,
  parameter int unsigned      NREG     = 32,
  parameter int unsigned      OUT_W    = 8,
  parameter logic [DW-1:0]    RESET_PC = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trigger_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [DW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i,
  input  logic             mem_ack_i,
  output logic [OUT_W-1:0] data_out,
  output logic             halted_o,
  output logic [DW-1:0]    instret_o
);

  localparam int unsigned AW = $clog2(NREG);

  if (DW != 32) begin : g_bad_dw
    $error("cpu_multicycle: DW must be 32");
  end
  if ((NREG != 16) && (NREG != 32)) begin : g_bad_nreg
    $error("cpu_multicycle: NREG must be 16 or 32");
  end
  if ((OUT_W < 1) || (OUT_W > DW)) begin : g_bad_out_w
    $error("cpu_multicycle: OUT_W must be in 1..DW");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_pc
    $error("cpu_multicycle: RESET_PC must be word-aligned");
  end

  state_e           state_q;
  logic [DW-1:0]    pc_q, ir_q, a_q, b_q, imm_q, res_q, npc_q, instret_q;
  logic             req_q, we_q;
  logic [DW-1:0]    addr_q, wdata_q;
  logic [OUT_W-1:0] dout_q;

  // Instruction fields
  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  logic [DW-1:0] rs1_val, rs2_val;

  cpu_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .raddr_a_i (rs1[AW-1:0]),
    .rdata_a_o (rs1_val),
    .raddr_b_i (rs2[AW-1:0]),
    .rdata_b_o (rs2_val),
    .we_i      (state_q == StWb),
    .waddr_i   (rd[AW-1:0]),
    .wdata_i   (res_q)
  );

  logic      legal, use_rd, use_rs1, use_rs2, idx_bad;
  imm_type_e imm_type;
  alu_op_e   alu_op;

  // Decode: legality, which register fields are live, immediate format and ALU operation
  always_comb begin
    legal    = 1'b0;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm_type = ImmI;
    case (opcode)
      OpLui, OpAuipc: begin legal = 1'b1; use_rd = 1'b1; imm_type = ImmU; end
      OpJal:          begin legal = 1'b1; use_rd = 1'b1; imm_type = ImmJ; end
      OpJalr:         begin legal = (f3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1; end
      OpBranch: begin
        legal    = (f3 != 3'b010) && (f3 != 3'b011);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        imm_type = ImmB;
      end
      OpLoad: begin legal = (f3 == F3Word); use_rd = 1'b1; use_rs1 = 1'b1; end
      OpStore: begin
        legal    = (f3 == F3Word);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        imm_type = ImmS;
      end
      OpImm: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        if (f3 == F3Sll)     legal = (f7 == F7Base);
        else if (f3 == F3Sr) legal = (f7 == F7Base) || (f7 == F7Alt);
        else                 legal = 1'b1;
      end
      OpReg: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        legal   = (f7 == F7Base) || ((f7 == F7Alt) && ((f3 == F3Add) || (f3 == F3Sr)));
      end
      default: ;
    endcase

    idx_bad = (use_rd && (32'(rd) >= NREG)) || (use_rs1 && (32'(rs1) >= NREG)) ||
              (use_rs2 && (32'(rs2) >= NREG));

    alu_op = AluAdd;
    if ((opcode == OpImm) || (opcode == OpReg)) begin
      case (f3)
        F3Add:   alu_op = ((opcode == OpReg) && (f7 == F7Alt)) ? AluSub : AluAdd;
        F3Sll:   alu_op = AluSll;
        F3Slt:   alu_op = AluSlt;
        F3Sltu:  alu_op = AluSltu;
        F3Xor:   alu_op = AluXor;
        F3Sr:    alu_op = (f7 == F7Alt) ? AluSra : AluSrl;
        F3Or:    alu_op = AluOr;
        default: alu_op = AluAnd;
      endcase
    end
  end

  logic [DW-1:0] op_a, op_b, alu_res, exec_res, exec_npc;
  logic          br_taken;

  // ALU, branch compare and next-PC selection for EXEC
  always_comb begin
    op_a = (opcode == OpLui) ? '0 : (opcode == OpAuipc) ? pc_q : a_q;
    op_b = (opcode == OpReg) ? b_q : imm_q;

    case (alu_op)
      AluSub:  alu_res = op_a - op_b;
      AluSll:  alu_res = op_a << op_b[4:0];
      AluSlt:  alu_res = {{(DW-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      AluSltu: alu_res = {{(DW-1){1'b0}}, op_a < op_b};
      AluXor:  alu_res = op_a ^ op_b;
      AluSrl:  alu_res = op_a >> op_b[4:0];
      AluSra:  alu_res = $signed(op_a) >>> op_b[4:0];
      AluOr:   alu_res = op_a | op_b;
      AluAnd:  alu_res = op_a & op_b;
      default: alu_res = op_a + op_b;
    endcase

    case (f3)
      F3Beq:   br_taken = (a_q == b_q);
      F3Bne:   br_taken = (a_q != b_q);
      F3Blt:   br_taken = ($signed(a_q) < $signed(b_q));
      F3Bge:   br_taken = ($signed(a_q) >= $signed(b_q));
      F3Bltu:  br_taken = (a_q < b_q);
      F3Bgeu:  br_taken = (a_q >= b_q);
      default: br_taken = 1'b0;
    endcase

    exec_npc = pc_q + 32'd4;
    if ((opcode == OpJal) || ((opcode == OpBranch) && br_taken)) begin
      exec_npc = pc_q + imm_q;
    end else if (opcode == OpJalr) begin
      exec_npc = {alu_res[DW-1:1], 1'b0};
    end

    exec_res = ((opcode == OpJal) || (opcode == OpJalr)) ? (pc_q + 32'd4) : alu_res;
  end

  // Control FSM with registered memory-port, display and counter outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      res_q     <= '0;
      npc_q     <= '0;
      instret_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger_i) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc_q;
          end
        end
        StFetch: begin
          if (mem_ack_i) begin
            ir_q    <= mem_rdata_i;
            req_q   <= 1'b0;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          a_q     <= rs1_val;
          b_q     <= rs2_val;
          imm_q   <= gen_imm(ir_q, imm_type);
          state_q <= (legal && !idx_bad) ? StExec : StHalt;
        end
        StExec: begin
          res_q <= exec_res;
          npc_q <= exec_npc;
          if ((opcode == OpLoad) || (opcode == OpStore)) begin
            if (alu_res[1:0] != 2'b00) begin
              state_q <= StHalt;
            end else begin
              state_q <= StMem;
              req_q   <= 1'b1;
              we_q    <= (opcode == OpStore);
              addr_q  <= alu_res;
              wdata_q <= b_q;
            end
          end else if (exec_npc[1:0] != 2'b00) begin
            // Only a taken branch or a jump can produce a misaligned target
            state_q <= StHalt;
          end else if (opcode == OpBranch) begin
            pc_q      <= exec_npc;
            instret_q <= instret_q + 32'd1;
            state_q   <= StFetch;
            req_q     <= 1'b1;
            addr_q    <= exec_npc;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (mem_ack_i) begin
            we_q <= 1'b0;
            if (we_q) begin
              pc_q      <= npc_q;
              instret_q <= instret_q + 32'd1;
              state_q   <= StFetch;
              addr_q    <= npc_q;
            end else begin
              res_q   <= mem_rdata_i;
              req_q   <= 1'b0;
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          if (rd == 5'd10) dout_q <= res_q[OUT_W-1:0];
          pc_q      <= npc_q;
          instret_q <= instret_q + 32'd1;
          state_q   <= StFetch;
          req_q     <= 1'b1;
          addr_q    <= npc_q;
        end
        StHalt: begin
          req_q <= 1'b0;
          we_q  <= 1'b0;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign data_out    = dout_q;
  assign halted_o    = (state_q == StHalt);
  assign instret_o   = instret_q;

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
Parametrised multi-cycle RV32I-subset core; next generation of the team's single-cycle cpu skeleton.
- One shared instruction/data memory port with a req/ack handshake, so wait-state memories are supported.
- Start gated by trigger_i; low OUT_W bits of x10 (a0) driven on data_out for the lab display.
- Adds a halt state on illegal/misaligned operations, a retired-instruction counter and a configurable register count (RV32E/RV32I).

Parameters:
DW, 32, datapath/register width; only 32 is supported, elaboration error otherwise
NREG, 32, architectural registers; 16 (RV32E) or 32
OUT_W, 8, width of data_out, 1..DW
RESET_PC, 32'h0000_0000, first fetch address; must be word-aligned

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
trigger_i  in  1  start request, sampled in IDLE only
mem_req_o  out  1  memory request; held until acknowledged
mem_we_o  out  1  1 = word store, 0 = word read
mem_addr_o  out  DW  byte address, always word-aligned when mem_req_o=1
mem_wdata_o  out  DW  store data
mem_rdata_i  in  DW  read data, valid when mem_ack_i=1
mem_ack_i  in  1  completes request; may be high in the same cycle as mem_req_o
data_out  out  OUT_W  x10[OUT_W-1:0]
halted_o  out  1  core in HALT state
instret_o  out  DW  retired instruction count

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous, active-high.
- Reset state: state=IDLE, PC=RESET_PC, all regs=0, instret=0.
- Reset outputs: data_out=0, halted_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- rst_i asserted mid-transaction: request dropped at that edge. The memory must tolerate an abandoned request.
- States and transitions:
  - IDLE: go to FETCH on the edge where trigger_i=1.
  - FETCH: mem_req_o=1, we=0, addr=PC. On ack, latch IR=mem_rdata_i and go to DECODE. Stay while ack=0.
  - DECODE: read rs1/rs2, form immediate (I/S/B/U/J). Go to EXEC, or to HALT if illegal.
  - EXEC: ALU op, branch compare, next-PC computation.
    - Loads/stores go to MEM.
    - Branches and stores do not write a register.
    - Branches retire here: PC updated, go to FETCH.
    - Everything else goes to WB.
  - MEM: mem_req_o=1, addr=rs1+imm, we=1 for SW with wdata=rs2. On ack, go to WB (LW) or FETCH (SW; retires here, PC+=4).
  - WB: write rd (ignored if rd=0), PC=next-PC, go to FETCH. The instruction retires here.
  - HALT: terminal until rst_i. halted_o=1, mem_req_o=0.
- Retire: instret increments by 1 (wraps modulo 2^DW) on the retiring edge.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LW, SW, all OP-IMM, all OP (base, no M).
- Go to HALT without retiring on any of:
  - any other opcode or funct combination;
  - rd/rs1/rs2 index >= NREG;
  - LW/SW effective address [1:0]≠0;
  - taken branch/JAL/JALR target [1:0]≠0 (JALR clears bit 0 first).
- Arithmetic is modulo 2^DW. Shifts use the low 5 bits of the shift amount. SRA/SRAI are arithmetic. SLT is signed, SLTU unsigned.
- Latency with zero-wait memory (ack in request cycle):
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles
  - branch: 3 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - Each memory wait cycle adds 1.
- Handshake: mem_addr_o, mem_we_o and mem_wdata_o are stable while mem_req_o=1 and ack=0. mem_req_o drops the cycle after ack.
- data_out updates the cycle after a write to x10.
- trigger_i is ignored outside IDLE.

Decomposition:
- Package cpu_pkg:
  - opcode constants;
  - funct3/funct7 constants;
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - ALU-op enum;
  - imm-type enum.
- Sub-module cpu_regfile:
  - NREG x DW, two combinational read ports, one synchronous write port;
  - x0 hardwired to 0;
  - synchronous reset clears all registers.
- ALU and decode stay inline in cpu_multicycle.

Test Plan:
- Reset, trigger_i=0 for 10 cycles -> mem_req_o never asserted, data_out=0. Pulse trigger_i -> first request addr=RESET_PC within 1 cycle.
- Program "ADDI x10,x0,0x5A; ADDI x10,x10,1; JAL x0,0", zero-wait memory -> data_out=8'h5B; instret_o=2 at cycle 8 after start, then increments by 1 every 4 cycles.
- Store/load: SW 0xDEADBEEF to 0x100, LW back to x10, memory ack delayed 3 cycles -> store request has we=1, addr=0x100 held 4 cycles. Loaded x10=0xDEADBEEF, data_out=8'hEF.
- Loop: BNE with a counter from 5 down to 0, x10 accumulating +2 per pass -> x10=10 at exit; branch instructions take 3 cycles each.
- Illegal opcode 0x0000_0000, and separately LW at address 0x102 -> halted_o=1, no request afterwards, instret_o unchanged. rst_i clears halted_o.
- NREG=16 build: ADDI x20,x0,1 -> HALT. rst_i asserted during an unacknowledged fetch -> mem_req_o=0 the next cycle, state IDLE.
